// File: rtl/poly_horner_bo.sv
// Horner-rule polynomial evaluator: one shared multiply/add step per cycle into a single accumulator.
// Define POLY_HORNER_OVF_EN to build the sticky per-evaluation overflow flag; otherwise ovf is tied low.
module poly_horner_bo #(
   parameter int W   = 16,
   parameter int DEG = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [W-1:0]         x,
   input  logic [W*(DEG+1)-1:0] coef,
   output logic                 busy,
   output logic                 done,
   output logic [W-1:0]         result,
   output logic                 ovf
);
   // state | meaning
   // IDLE  | waiting for start; result and ovf hold the last evaluation
   // MUL   | acc <= acc * x
   // ADD   | acc <= acc + c_idx; the idx == 0 pass publishes the result
   typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, ADD = 2'd2} state_t;

   localparam int IW = (DEG > 1) ? $clog2(DEG) : 1;

   state_t           state_q;
   logic [W-1:0]     x_q;
   logic [W*DEG-1:0] coef_q;
   logic [W-1:0]     acc_q;
   logic [IW-1:0]    idx_q;
   logic [W-1:0]     result_q;
   logic             done_q;
   logic [W-1:0]     c_sel;

   // c_DEG goes straight into the accumulator at start, so only c_0..c_DEG-1 are snapshotted.
   always_comb begin
      c_sel = '0;
      for (int i = 0; i < DEG; i++) begin
         if (idx_q == IW'(i)) c_sel = coef_q[W*i +: W];
      end
   end

`ifdef POLY_HORNER_OVF_EN
   logic [2*W-1:0] prod;
   logic [W:0]     sum;
   logic           ovf_q;

   assign prod = {{W{1'b0}}, acc_q} * {{W{1'b0}}, x_q};
   assign sum  = {1'b0, acc_q} + {1'b0, c_sel};
   assign ovf  = ovf_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE:    if (start) ovf_q <= 1'b0;
            MUL:     if (|prod[2*W-1:W]) ovf_q <= 1'b1;
            ADD:     if (sum[W]) ovf_q <= 1'b1;
            default: ovf_q <= ovf_q;
         endcase
      end
   end
`else
   logic [W-1:0] prod;
   logic [W-1:0] sum;

   assign prod = acc_q * x_q;
   assign sum  = acc_q + c_sel;
   assign ovf  = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         x_q      <= '0;
         coef_q   <= '0;
         acc_q    <= '0;
         idx_q    <= '0;
         result_q <= '0;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  x_q     <= x;
                  coef_q  <= coef[W*DEG-1:0];
                  acc_q   <= coef[W*DEG +: W];
                  idx_q   <= IW'(DEG - 1);
                  state_q <= MUL;
               end
            end
            MUL: begin
               acc_q   <= prod[W-1:0];
               state_q <= ADD;
            end
            ADD: begin
               acc_q <= sum[W-1:0];
               if (idx_q == '0) begin
                  result_q <= sum[W-1:0];
                  done_q   <= 1'b1;
                  state_q  <= IDLE;
               end else begin
                  idx_q   <= idx_q - IW'(1);
                  state_q <= MUL;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy   = (state_q != IDLE);
   assign done   = done_q;
   assign result = result_q;

endmodule

// File: tb/tb_poly_horner_bo.sv
// Self-checking bench for poly_horner_bo: three instances (W16/DEG2, W8/DEG2, W16/DEG1), vector table,
// randomized evaluations against a plain-arithmetic model, and hand sequences for hold/reset/snapshot cases.
module tb_poly_horner_bo;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst_n;

   logic        s16, b16, d16, o16;
   logic [15:0] x16, r16;
   logic [47:0] c16;

   logic        s8, b8, d8, o8;
   logic [7:0]  x8, r8;
   logic [23:0] c8;

   logic        s1, b1, d1, o1;
   logic [15:0] x1, r1;
   logic [31:0] c1v;

   int errors = 0;
   int checks = 0;

`ifdef POLY_HORNER_OVF_EN
   localparam bit OVF_ON = 1'b1;
`else
   localparam bit OVF_ON = 1'b0;
`endif

   poly_horner_bo #(.W(16), .DEG(2)) u16 (
      .clk(clk), .rst_n(rst_n), .start(s16), .x(x16), .coef(c16),
      .busy(b16), .done(d16), .result(r16), .ovf(o16));

   poly_horner_bo #(.W(8), .DEG(2)) u8 (
      .clk(clk), .rst_n(rst_n), .start(s8), .x(x8), .coef(c8),
      .busy(b8), .done(d8), .result(r8), .ovf(o8));

   poly_horner_bo #(.W(16), .DEG(1)) u1 (
      .clk(clk), .rst_n(rst_n), .start(s1), .x(x1), .coef(c1v),
      .busy(b1), .done(d1), .result(r1), .ovf(o1));

   typedef struct {
      logic [15:0] x;
      logic [15:0] c2, c1, c0;
      logic [15:0] exp_res;
      logic        exp_ovf;
   } vec_t;

   vec_t vecs[6];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=0x%0h required=0x%0h", nm, act, exp);
      end
   endtask

   // Direct polynomial value mod 2^16, plus overflow from the Horner step sequence with unbounded arithmetic.
   function automatic void model16(input longint unsigned xv, input longint unsigned c2,
                                   input longint unsigned c1, input longint unsigned c0,
                                   output logic [15:0] res, output logic ov);
      longint unsigned m = 64'd65536;
      longint unsigned t, a;
      t   = (c2 * ((xv * xv) % m)) % m + (c1 * xv) % m + c0;
      res = 16'(t % m);
      ov  = 1'b0;
      a = c2 * xv;       if (a >= m) ov = 1'b1; a = a % m;
      a = a + c1;        if (a >= m) ov = 1'b1; a = a % m;
      a = a * xv;        if (a >= m) ov = 1'b1; a = a % m;
      a = a + c0;        if (a >= m) ov = 1'b1;
   endfunction

   task automatic eval16(input logic [15:0] xv, input logic [47:0] cv, input bit scramble,
                         output logic [15:0] res, output logic ov, output int lat, output int bcnt);
      int k;
      @(negedge clk);
      x16 = xv; c16 = cv; s16 = 1'b1;
      @(negedge clk);
      s16 = 1'b0;
      if (scramble) begin
         x16 = '0; c16 = '0;
      end
      k = 1;
      bcnt = b16 ? 1 : 0;
      while (!d16 && k < 20) begin
         @(negedge clk);
         k++;
         if (b16) bcnt++;
      end
      lat = k - 1;
      res = r16;
      ov  = o16;
      @(negedge clk);
      chk("done_one_cycle", {63'd0, d16}, 64'd0);
   endtask

   initial begin
      logic [15:0] res, mres;
      logic        ov, mov;
      int          lat, bcnt, k, cnt, first, prev;
      bit          seen;

      vecs[0] = '{16'd5,      16'd3,      16'd2, 16'd1, 16'd86,     1'b0};
      vecs[1] = '{16'd0,      16'd7,      16'd8, 16'd9, 16'd9,      1'b0};
      vecs[2] = '{16'd2,      16'd1,      16'd1, 16'd1, 16'd7,      1'b0};
      vecs[3] = '{16'h0100,   16'd1,      16'd0, 16'd3, 16'd3,      1'b1};
      vecs[4] = '{16'hFFFF,   16'd0,      16'd1, 16'd0, 16'hFFFF,   1'b0};
      vecs[5] = '{16'd1,      16'hFFFF,   16'd1, 16'd0, 16'd0,      1'b1};

      rst_n = 1'b0;
      s16 = 0; x16 = '0; c16 = '0;
      s8  = 0; x8  = '0; c8  = '0;
      s1  = 0; x1  = '0; c1v = '0;
      repeat (2) @(negedge clk);
      chk("rst_busy16",   {63'd0, b16}, 64'd0);
      chk("rst_done16",   {63'd0, d16}, 64'd0);
      chk("rst_result16", {48'd0, r16}, 64'd0);
      chk("rst_ovf16",    {63'd0, o16}, 64'd0);
      chk("rst_busy8",    {63'd0, b8},  64'd0);
      chk("rst_result8",  {56'd0, r8},  64'd0);
      chk("rst_busy1",    {63'd0, b1},  64'd0);
      chk("rst_result1",  {48'd0, r1},  64'd0);
      rst_n = 1'b1;

      for (int i = 0; i < 6; i++) begin
         eval16(vecs[i].x, {vecs[i].c2, vecs[i].c1, vecs[i].c0}, 1'b0, res, ov, lat, bcnt);
         chk($sformatf("vec%0d_latency", i), 64'(lat), 64'd4);
         chk($sformatf("vec%0d_busy_cycles", i), 64'(bcnt), 64'd4);
         chk($sformatf("vec%0d_result", i), {48'd0, res}, {48'd0, vecs[i].exp_res});
         chk($sformatf("vec%0d_ovf", i), {63'd0, ov}, {63'd0, vecs[i].exp_ovf & OVF_ON});
      end

      for (int i = 0; i < 24; i++) begin
         logic [15:0] rx, ra, rb, rc;
         rx = 16'($urandom);
         ra = 16'($urandom);
         rb = 16'($urandom);
         rc = 16'($urandom);
         if (i % 3 == 0) begin
            rx = 16'($urandom_range(0, 15));
            ra = 16'($urandom_range(0, 15));
         end
         model16(64'(rx), 64'(ra), 64'(rb), 64'(rc), mres, mov);
         eval16(rx, {ra, rb, rc}, 1'b0, res, ov, lat, bcnt);
         chk($sformatf("rand%0d_result", i), {48'd0, res}, {48'd0, mres});
         chk($sformatf("rand%0d_ovf", i), {63'd0, ov}, {63'd0, mov & OVF_ON});
      end

      eval16(16'd5, {16'd3, 16'd2, 16'd1}, 1'b1, res, ov, lat, bcnt);
      chk("snapshot_result", {48'd0, res}, 64'd86);
      chk("snapshot_latency", 64'(lat), 64'd4);

      @(negedge clk);
      x16 = 16'd5; c16 = {16'd3, 16'd2, 16'd1}; s16 = 1'b1;
      cnt = 0; first = 0; prev = 0;
      for (int j = 1; j <= 16; j++) begin
         @(negedge clk);
         if (d16) begin
            cnt++;
            chk("held_result", {48'd0, r16}, 64'd86);
            if (cnt == 1) first = j;
            else chk("held_gap", 64'(j - prev), 64'd5);
            prev = j;
         end
      end
      s16 = 1'b0;
      chk("held_first_done", 64'(first), 64'd5);
      chk("held_done_count", 64'(cnt), 64'd3);
      k = 0;
      while (b16 && k < 20) begin
         @(negedge clk);
         k++;
      end
      chk("held_back_idle", {63'd0, b16}, 64'd0);
      @(negedge clk);

      @(negedge clk);
      x8 = 8'd16; c8 = {8'd1, 8'd0, 8'd5}; s8 = 1'b1;
      @(negedge clk);
      s8 = 1'b0;
      k = 1;
      while (!d8 && k < 20) begin
         @(negedge clk);
         k++;
      end
      chk("w8_latency", 64'(k - 1), 64'd4);
      chk("w8_result", {56'd0, r8}, 64'd5);
      chk("w8_ovf", {63'd0, o8}, {63'd0, OVF_ON});

      @(negedge clk);
      x1 = 16'd1; c1v = {16'hFFFF, 16'd2}; s1 = 1'b1;
      @(negedge clk);
      s1 = 1'b0;
      k = 1;
      while (!d1 && k < 20) begin
         @(negedge clk);
         k++;
      end
      chk("deg1_latency", 64'(k - 1), 64'd2);
      chk("deg1_result", {48'd0, r1}, 64'h0001);
      chk("deg1_ovf", {63'd0, o1}, {63'd0, OVF_ON});

      @(negedge clk);
      x16 = 16'd5; c16 = {16'd3, 16'd2, 16'd1}; s16 = 1'b1;
      @(negedge clk);
      s16 = 1'b0;
      @(negedge clk);
      chk("pre_reset_busy", {63'd0, b16}, 64'd1);
      rst_n = 1'b0;
      #1;
      chk("mid_reset_busy", {63'd0, b16}, 64'd0);
      chk("mid_reset_result", {48'd0, r16}, 64'd0);
      chk("mid_reset_done", {63'd0, d16}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      repeat (8) begin
         @(negedge clk);
         if (d16) seen = 1'b1;
      end
      chk("reset_no_done", {63'd0, seen}, 64'd0);
      chk("reset_result_held", {48'd0, r16}, 64'd0);
      eval16(16'd2, {16'd1, 16'd1, 16'd1}, 1'b0, res, ov, lat, bcnt);
      chk("post_reset_result", {48'd0, res}, 64'd7);
      chk("post_reset_latency", 64'(lat), 64'd4);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/poly_horner_bo.md
Name: poly_horner_bo

Overview:
- Parametrised polynomial-evaluation datapath with its own control FSM; successor to the fixed second-order operative block.
- Evaluates y = c_DEG*x^DEG + ... + c_1*x + c_0 by Horner's rule on one shared multiply/add unit and one accumulator register.
- Sits between the top-level controller (start/done handshake) and the result consumer.
- Generalised in word width and polynomial degree; adds reset, handshake, input snapshotting and optional overflow detection.

Parameters:
- W, 16, data width of x, each coefficient, the accumulator and the result (W >= 2).
- DEG, 2, polynomial degree (DEG >= 1); DEG+1 coefficients.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- x  input  W  evaluation point, unsigned
- coef  input  W*(DEG+1)  coefficients, unsigned; c_i = coef[W*i +: W]
- busy  output  1  high while an evaluation is in progress
- done  output  1  one-cycle pulse when result is updated
- result  output  W  last completed evaluation, held until the next done
- ovf  output  1  overflow flag (see Optional Feature)

Behaviour:
- Reset, async on rst_n low: state=IDLE; busy=0, done=0, result=0, ovf=0, accumulator=0, index=0. Reset mid-evaluation aborts it; result keeps 0 from reset, no done pulse.
- FSM states: IDLE, MUL, ADD.
- IDLE, start=1 at edge E0:
  - snapshot x and all coef into internal registers;
  - acc <= c_DEG, idx <= DEG-1, ovf <= 0 (when enabled);
  - state <= MUL.
- MUL: acc <= (acc*x) mod 2^W; state <= ADD.
- ADD: acc <= (acc + c_idx) mod 2^W.
  - If idx != 0: idx <= idx-1, state <= MUL.
  - If idx == 0: result <= acc + c_0 (mod 2^W), done <= 1, state <= IDLE.
- Latency: done high in the cycle after edge E0+2*DEG (DEG=2: 4 edges after the start edge).
- busy = (state != IDLE), registered with the state; busy=0 during the done cycle.
- done: high exactly one cycle, otherwise 0.
- start while busy is ignored and not queued.
- Back-to-back: start=1 during the done cycle is accepted; next evaluation begins on that edge.
- x and coef may change freely after E0 without affecting the current evaluation.
- Arithmetic: all operations are unsigned and truncated to W bits. Full product is 2W bits internally; only the low W bits are kept.

Optional Feature:
- Macro POLY_HORNER_OVF_EN.
- Defined:
  - ovf is sticky per evaluation and cleared at E0.
  - Set when any MUL has nonzero product bits [2W-1:W], or when any ADD carries out of bit W-1.
  - ovf is valid with done and holds until the next E0.
- Not defined: ovf is tied to 0 and no overflow logic is synthesised.

Test Plan:
- W=16, DEG=2, c2=3, c1=2, c0=1, x=5, pulse start -> done pulses exactly 4 cycles after the start edge; result=86; busy high 4 cycles; ovf=0.
- Same config, start held high for 10 cycles -> evaluations accepted only in IDLE/done cycles; done every 5th cycle, each with result=86.
- W=8, DEG=2, c2=1, c1=0, c0=5, x=16 -> result=5 (256 wraps to 0). With macro ovf=1; without macro ovf=0.
- DEG=2, start accepted, then x and coef changed to 0 on the next cycle -> result still 86.
- Start an evaluation, assert rst_n=0 on the 2nd busy cycle, release -> busy=0, result=0, done never pulses. A following start with x=2, c2=c1=c0=1 -> result=7.
- W=16, DEG=1, c1=0xFFFF, c0=2, x=1 -> done 2 cycles after start; result=0x0001. With macro ovf=1 (add carry).
